// File: rtl/pam4_tx_encoder_if.sv
// Handshake and status bundle between a serial bit source / PAM4 channel model
// and the PAM4 transmit encoder.
interface pam4_tx_encoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic             flush;
    logic [1:0]       symbol_out;
    logic [7:0]       voltage_level_out;
    logic             voltage_level_out_valid;
    logic             voltage_level_out_ready;
    logic             pending;
    logic [CNT_W-1:0] symbol_count;

    modport slave (
        input  data_in,
        input  data_in_valid,
        input  flush,
        input  voltage_level_out_ready,
        output data_in_ready,
        output symbol_out,
        output voltage_level_out,
        output voltage_level_out_valid,
        output pending,
        output symbol_count
    );

    modport master (
        output data_in,
        output data_in_valid,
        output flush,
        output voltage_level_out_ready,
        input  data_in_ready,
        input  symbol_out,
        input  voltage_level_out,
        input  voltage_level_out_valid,
        input  pending,
        input  symbol_count
    );
endinterface

// File: rtl/pam4_tx_encoder.sv
// Serial-to-pair packer with Gray mapping to PAM4 level index and voltage code,
// buffered by a 2-entry ready/valid FIFO and a wrapping symbol counter.
module pam4_tx_encoder #(
    parameter logic [7:0]  LVL0  = 8'd0,
    parameter logic [7:0]  LVL1  = 8'd85,
    parameter logic [7:0]  LVL2  = 8'd170,
    parameter logic [7:0]  LVL3  = 8'd255,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk_clk,
    input logic              reset_reset_n,
    pam4_tx_encoder_if.slave bus
);

    logic             pending_q, pending_d;
    logic             held_q, held_d;
    logic [1:0]       mem_q [2];
    logic [1:0]       mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [1:0]       head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic       in_ready;
    logic       accept;
    logic       do_flush;
    logic       push;
    logic       pop;
    logic [1:0] pair;
    logic [1:0] idx;
    logic [7:0] volt;

    always_comb begin
        fifo_full  = (occ_q == 2'd2);
        fifo_empty = (occ_q == 2'd0);
        in_ready   = !(pending_q && fifo_full);
        accept     = bus.data_in_valid && in_ready;
        do_flush   = !bus.data_in_valid && bus.flush && pending_q && !fifo_full;
        pop        = !fifo_empty && bus.voltage_level_out_ready;
        push       = (accept && pending_q) || do_flush;
        // A flush only fires with data_in_valid low, so the pad bit is 0.
        pair       = {held_q, accept ? bus.data_in : 1'b0};
        idx        = {pair[1], pair[1] ^ pair[0]};

        pending_d = pending_q;
        held_d    = held_q;
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        head_d    = head_q;
        count_d   = count_q;

        if (accept && !pending_q) begin
            held_d    = bus.data_in;
            pending_d = 1'b1;
        end else if (push) begin
            pending_d = 1'b0;
        end

        if (push) begin
            mem_d[wr_ptr_q] = idx;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            count_d  = count_q + 1'b1;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};

        // The head register follows the new FIFO head, and holds when the FIFO drains.
        if (occ_d != 2'd0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pending_q <= 1'b0;
            held_q    <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            occ_q     <= '0;
            head_q    <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            held_q    <= held_d;
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            head_q    <= head_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        volt = LVL0;
        unique case (head_q)
            2'd0: volt = LVL0;
            2'd1: volt = LVL1;
            2'd2: volt = LVL2;
            2'd3: volt = LVL3;
            default: volt = LVL0;
        endcase
    end

    assign bus.data_in_ready           = in_ready;
    assign bus.symbol_out              = head_q;
    assign bus.voltage_level_out       = volt;
    assign bus.voltage_level_out_valid = !fifo_empty;
    assign bus.pending                 = pending_q;
    assign bus.symbol_count            = count_q;

endmodule
